// File: rtl/rijndael_pkg.sv
// Shared types and helpers for the masked Rijndael SubBytes datapath.
//   state_e    : controller states (IDLE, SUB, DONE)
//   byte_t     : one state byte
//   num_passes : S-box passes per transaction (NBYTES / NSBOX)
package rijndael_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SUB  = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef logic [7:0] byte_t;

   // A zero NSBOX is rejected at elaboration; avoid dividing by it here.
   function automatic int unsigned num_passes(input int unsigned nbytes,
                                              input int unsigned nsbox);
      return (nsbox == 0) ? 0 : nbytes / nsbox;
   endfunction

endpackage

// File: rtl/bSbox.sv
// Masked Rijndael S-box, one byte.
//   data_i    : masked input byte (true value is data_i ^ imask_i)
//   imask_i   : input mask
//   omask_i   : output mask
//   encrypt_i : 1 = SubBytes, 0 = InvSubBytes
//   q_o       : S-box result XOR omask_i
module bSbox (
   input  logic [7:0] data_i,
   input  logic [7:0] imask_i,
   input  logic [7:0] omask_i,
   input  logic       encrypt_i,
   output logic [7:0] q_o
);

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r;
      logic [7:0] sq;
      logic [7:0] e;
      r  = 8'h01;
      sq = x;
      e  = 8'hfe;
      for (int i = 0; i < 8; i++) begin
         if (e[i]) r = gf_mul(r, sq);
         sq = gf_mul(sq, sq);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl(input logic [7:0] a, input int unsigned n);
      return (a << n) | (a >> (8 - n));
   endfunction

   logic [7:0] x;
   logic [7:0] inv;
   logic [7:0] y;

   always_comb begin
      x   = data_i ^ imask_i;
      inv = 8'h00;
      if (encrypt_i) begin
         inv = gf_inv(x);
         y   = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      end else begin
         y = gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
      end
      q_o = y ^ omask_i;
   end

endmodule

// File: rtl/rijndael_sbox_lane.sv
// One S-box lane: picks byte LANE out of the low NSBOX-byte window of the
// data/imask/omask registers and feeds it to a bSbox.
//   data_i, imask_i, omask_i : low NSBOX bytes of the state/mask registers
//   encrypt_i                : S-box direction
//   q_o                      : masked S-box output for this lane
module rijndael_sbox_lane
   import rijndael_pkg::*;
#(
   parameter int unsigned NSBOX = 4,
   parameter int unsigned LANE  = 0
) (
   input  logic [8*NSBOX-1:0] data_i,
   input  logic [8*NSBOX-1:0] imask_i,
   input  logic [8*NSBOX-1:0] omask_i,
   input  logic               encrypt_i,
   output logic [7:0]         q_o
);

   byte_t data_b;
   byte_t imask_b;
   byte_t omask_b;

   assign data_b  = data_i[8*LANE +: 8];
   assign imask_b = imask_i[8*LANE +: 8];
   assign omask_b = omask_i[8*LANE +: 8];

   bSbox u_bsbox (
      .data_i    (data_b),
      .imask_i   (imask_b),
      .omask_i   (omask_b),
      .encrypt_i (encrypt_i),
      .q_o       (q_o)
   );

endmodule

// File: rtl/rijndael_masked_sub_bytes.sv
// Masked Rijndael SubBytes over an NBYTES-byte state using NSBOX shared
// S-box lanes, time-multiplexed over NBYTES/NSBOX passes, valid/ready on
// both sides.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : input handshake (ready only in IDLE)
//   din, key             : state and round key, byte i at [8i+7:8i]
//   imask, omask         : per-byte input / output masks
//   out_valid/out_ready  : output handshake (valid only in DONE)
//   dout                 : result, unmasked with the captured omask if UNMASK_OUT
// Optional macro RIJNDAEL_SUB_BYTES_INV_EN adds a 'decrypt' input selecting
// InvSubBytes; without it only the forward S-box is built.
module rijndael_masked_sub_bytes
   import rijndael_pkg::*;
#(
   parameter int unsigned NBYTES     = 16,
   parameter int unsigned NSBOX      = 4,
   parameter bit          UNMASK_OUT = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [8*NBYTES-1:0] din,
   input  logic [8*NBYTES-1:0] key,
   input  logic [8*NBYTES-1:0] imask,
   input  logic [8*NBYTES-1:0] omask,
`ifdef RIJNDAEL_SUB_BYTES_INV_EN
   input  logic                decrypt,
`endif
   output logic                out_valid,
   input  logic                out_ready,
   output logic [8*NBYTES-1:0] dout
);

   if (NSBOX < 1) begin : g_err_nsbox
      $error("NSBOX must be at least 1");
   end else if (NBYTES % NSBOX != 0) begin : g_err_div
      $error("NBYTES must be a multiple of NSBOX");
   end

   localparam int unsigned NPASS = num_passes(NBYTES, NSBOX);
   localparam int unsigned CW    = (NPASS > 1) ? $clog2(NPASS) : 1;
   localparam int unsigned W     = 8 * NBYTES;
   localparam int unsigned LW    = 8 * NSBOX;
   localparam logic [CW-1:0] CNT_LAST = CW'(NPASS - 1);

   state_e          state_q, state_d;
   logic [W-1:0]    data_q, data_d;
   logic [W-1:0]    imask_q, imask_d;
   logic [W-1:0]    omask_q, omask_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [LW-1:0]   sbox_out;
   logic            encrypt;

`ifdef RIJNDAEL_SUB_BYTES_INV_EN
   logic decrypt_q, decrypt_d;
   assign encrypt = ~decrypt_q;
`else
   assign encrypt = 1'b1;
`endif

   for (genvar i = 0; i < NSBOX; i++) begin : g_lane
      rijndael_sbox_lane #(
         .NSBOX (NSBOX),
         .LANE  (i)
      ) u_lane (
         .data_i    (data_q[LW-1:0]),
         .imask_i   (imask_q[LW-1:0]),
         .omask_i   (omask_q[LW-1:0]),
         .encrypt_i (encrypt),
         .q_o       (sbox_out[8*i +: 8])
      );
   end

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      imask_d = imask_q;
      omask_d = omask_q;
      cnt_d   = cnt_q;
`ifdef RIJNDAEL_SUB_BYTES_INV_EN
      decrypt_d = decrypt_q;
`endif
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d  = din ^ key ^ imask;
               imask_d = imask;
               omask_d = omask;
               cnt_d   = '0;
               state_d = SUB;
`ifdef RIJNDAEL_SUB_BYTES_INV_EN
               decrypt_d = decrypt;
`endif
            end
         end
         SUB: begin
            // Rotate right by NSBOX bytes; fresh S-box results enter at the top,
            // so after NPASS passes every byte is back in its original slot.
            data_d           = data_q >> LW;
            data_d[W-1 -: LW] = sbox_out;
            imask_d          = (imask_q >> LW) | (imask_q << (W - LW));
            omask_d          = (omask_q >> LW) | (omask_q << (W - LW));
            cnt_d            = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) state_d = DONE;
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         data_q  <= '0;
         imask_q <= '0;
         omask_q <= '0;
         cnt_q   <= '0;
`ifdef RIJNDAEL_SUB_BYTES_INV_EN
         decrypt_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         imask_q <= imask_d;
         omask_q <= omask_d;
         cnt_q   <= cnt_d;
`ifdef RIJNDAEL_SUB_BYTES_INV_EN
         decrypt_q <= decrypt_d;
`endif
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   // Captured omask only: the live port may change while the result is held.
   assign dout      = UNMASK_OUT ? (data_q ^ omask_q) : data_q;

endmodule
